// File: rtl/spi_mem_responder_pkg.sv
// Shared opcodes, FSM state type and mode-register reset value for spi_mem_responder.
package spi_mem_responder_pkg;

   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_WRITE   = 8'h02;
   localparam logic [7:0] OP_RDSR    = 8'h05;
   localparam logic [7:0] OP_WRSR    = 8'h01;
   localparam logic [7:0] MODE_RESET = 8'h40;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_WRITE,
      ST_STATUS,
      ST_IGNORE
   } state_t;

endpackage

// File: rtl/spi_mem_responder_sync.sv
// Two-flop synchronisers for the SPI pins plus edge detection in the clk domain.
module spi_mem_responder_sync (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi_s,
   output logic cs_n_s
);

   logic [1:0] sclk_ff;
   logic [1:0] cs_ff;
   logic [1:0] mosi_ff;
   logic       sclk_q;
   logic       cs_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_ff <= '0;
         cs_ff   <= '1;
         mosi_ff <= '0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b1;
      end else begin
         sclk_ff <= {sclk_ff[0], sclk};
         cs_ff   <= {cs_ff[0], cs_n};
         mosi_ff <= {mosi_ff[0], mosi};
         sclk_q  <= sclk_ff[1];
         cs_q    <= cs_ff[1];
      end
   end

   assign sclk_rise = sclk_ff[1] & ~sclk_q;
   assign sclk_fall = ~sclk_ff[1] & sclk_q;
   assign cs_fall   = ~cs_ff[1] & cs_q;
   assign cs_rise   = cs_ff[1] & ~cs_q;
   assign mosi_s    = mosi_ff[1];
   assign cs_n_s    = cs_ff[1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder (READ 0x03 / WRITE 0x02, 16/24-bit address).
// Define SPI_MEM_RESPONDER_STATUS_EN to add RDSR/WRSR and the 8-bit mode register.
module spi_mem_responder
   import spi_mem_responder_pkg::*;
#(
   parameter int unsigned CLK_PER_SCLK_MIN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic        addr_24bit,
   output logic [23:0] mem_addr,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        mem_we,
   output logic [7:0]  mem_wdata
);

   // Read prefetch needs ~3 clk between an sclk rise and the following fall.
   if (CLK_PER_SCLK_MIN < 6) begin : g_ratio_check
      $error("spi_mem_responder: CLK_PER_SCLK_MIN must be at least 6");
   end

   state_t      state, next_state;
   logic        sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s, cs_n_s;
   logic [4:0]  bit_cnt;
   logic [6:0]  shift_in;
   logic [7:0]  shift_out;
   logic [7:0]  byte_in;
   logic        miso_r;
   logic        a24;
   logic        is_read;
   logic        re_d;
   logic [1:0]  warm;
   logic        armed;
   logic        start;
   logic        byte_done;
   logic        addr_done;
   logic [23:0] next_addr;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
   logic [7:0]  mode_reg;
   logic        is_wrsr;
`endif

   spi_mem_responder_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .mosi_s    (mosi_s),
      .cs_n_s    (cs_n_s)
   );

   assign byte_in   = {shift_in, mosi_s};
   assign byte_done = sclk_rise && (bit_cnt[2:0] == 3'd7);
   assign addr_done = sclk_rise && (bit_cnt == (a24 ? 5'd23 : 5'd15));
   // A cs_n already low when reset releases must not start a transaction.
   assign start     = cs_fall && armed;
   assign next_addr = a24 ? mem_addr + 24'd1 : {8'h00, mem_addr[15:0] + 16'd1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      miso_oe    = 1'b0;
      miso       = 1'b0;
      if (cs_rise) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) next_state = ST_CMD;
            ST_CMD: begin
               if (byte_done) begin
                  case (byte_in)
                     OP_READ, OP_WRITE: next_state = ST_ADDR;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
                     OP_RDSR: next_state = ST_STATUS;
                     OP_WRSR: next_state = ST_WRITE;
`else
                     OP_RDSR, OP_WRSR: next_state = ST_IGNORE;
`endif
                     default: next_state = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: if (addr_done) next_state = is_read ? ST_READ : ST_WRITE;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
            ST_WRITE: if (is_wrsr && byte_done) next_state = ST_IGNORE;
`endif
            default: next_state = state;
         endcase
      end
      miso_oe = ((state == ST_READ) || (state == ST_STATUS)) && !cs_n_s;
      miso    = miso_oe & miso_r;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         shift_in  <= '0;
         shift_out <= '0;
         miso_r    <= 1'b0;
         a24       <= 1'b0;
         is_read   <= 1'b0;
         re_d      <= 1'b0;
         warm      <= '0;
         armed     <= 1'b0;
         mem_addr  <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
         mode_reg  <= MODE_RESET;
         is_wrsr   <= 1'b0;
`endif
      end else begin
         mem_re <= 1'b0;
         mem_we <= 1'b0;
         re_d   <= mem_re;
         if (warm != 2'd3) warm <= warm + 2'd1;
         else if (cs_n_s)  armed <= 1'b1;
         if (mem_we) mem_addr <= next_addr;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  bit_cnt  <= '0;
                  mem_addr <= '0;
                  a24      <= addr_24bit;
                  miso_r   <= 1'b0;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  shift_in <= byte_in[6:0];
                  bit_cnt  <= bit_cnt + 5'd1;
               end
               if (byte_done) begin
                  bit_cnt <= '0;
                  is_read <= (byte_in == OP_READ);
`ifdef SPI_MEM_RESPONDER_STATUS_EN
                  is_wrsr <= (byte_in == OP_WRSR);
                  if (byte_in == OP_RDSR) shift_out <= mode_reg;
`endif
               end
            end
            ST_ADDR: begin
               if (sclk_rise) begin
                  mem_addr <= {mem_addr[22:0], mosi_s};
                  bit_cnt  <= bit_cnt + 5'd1;
               end
               if (addr_done) begin
                  bit_cnt <= '0;
                  if (is_read) mem_re <= 1'b1;
               end
            end
            ST_READ: begin
               if (sclk_rise) begin
                  shift_out <= {shift_out[6:0], 1'b0};
                  bit_cnt   <= bit_cnt + 5'd1;
               end
               if (byte_done) begin
                  bit_cnt  <= '0;
                  mem_re   <= 1'b1;
                  mem_addr <= next_addr;
               end
               if (sclk_fall) miso_r <= shift_out[7];
               if (re_d)      shift_out <= mem_rdata;
            end
            ST_WRITE: begin
               if (sclk_rise) begin
                  shift_in <= byte_in[6:0];
                  bit_cnt  <= bit_cnt + 5'd1;
               end
               if (byte_done) begin
                  bit_cnt <= '0;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
                  if (is_wrsr) begin
                     mode_reg <= byte_in;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_wdata <= byte_in;
                  end
`else
                  mem_we    <= 1'b1;
                  mem_wdata <= byte_in;
`endif
               end
            end
`ifdef SPI_MEM_RESPONDER_STATUS_EN
            ST_STATUS: begin
               if (sclk_rise) begin
                  shift_out <= {shift_out[6:0], 1'b0};
                  bit_cnt   <= bit_cnt + 5'd1;
               end
               if (byte_done) begin
                  bit_cnt   <= '0;
                  shift_out <= mode_reg;
               end
               if (sclk_fall) miso_r <= shift_out[7];
            end
`endif
            default: ;
         endcase

         if (cs_rise) bit_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench for spi_mem_responder: randomized SPI transactions vs. a transaction-level model.
module tb_spi_mem_responder;

   localparam int unsigned HALF = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        addr_24bit = 1'b0;
   logic        miso, miso_oe, mem_re, mem_we;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata = '0;
   logic [7:0]  mem_wdata;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned oe_cycles = 0;
   int unsigned we_cycles = 0;

   logic [23:0] exp_re[$];
   logic [31:0] exp_we[$];
   logic [7:0]  exp_rx[$];
   logic [7:0]  env_mem[logic [23:0]];
   logic [7:0]  ref_mem[logic [23:0]];
`ifdef SPI_MEM_RESPONDER_STATUS_EN
   logic [7:0]  mode_m = 8'h40;
`endif

   spi_mem_responder #(.CLK_PER_SCLK_MIN(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .addr_24bit (addr_24bit),
      .mem_addr   (mem_addr),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dflt(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [23:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Memory seen by the DUT: data one clk after mem_re, writes land on mem_we.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
      if (mem_we) env_mem[mem_addr] = mem_wdata;
   end

   // Strobe monitor.
   always @(negedge clk) begin
      if (miso_oe) oe_cycles++;
      if (mem_re || mem_we) check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
      if (mem_we) begin
         we_cycles++;
         check("we_pending", 32'(exp_we.size() != 0), 32'd1);
         if (exp_we.size() != 0) check("we_addr_data", {mem_addr, mem_wdata}, exp_we.pop_front());
      end
      if (mem_re) begin
         check("re_pending", 32'(exp_re.size() != 0), 32'd1);
         if (exp_re.size() != 0) check("re_addr", 32'(mem_addr), 32'(exp_re.pop_front()));
      end
   end

   // SPI receive monitor: the initiator samples miso on sclk rise.
   int unsigned rx_cnt = 0;
   logic [7:0]  rx_sh = '0;
   always @(posedge sclk or posedge cs_n) begin
      if (cs_n) begin
         rx_cnt = 0;
      end else if (miso_oe) begin
         rx_sh = {rx_sh[6:0], miso};
         rx_cnt++;
         if (rx_cnt == 8) begin
            rx_cnt = 0;
            check("rx_pending", 32'(exp_rx.size() != 0), 32'd1);
            if (exp_rx.size() != 0) check("miso_byte", 32'(rx_sh), 32'(exp_rx.pop_front()));
         end
      end
   end

   function automatic logic [23:0] wrap(input logic [23:0] base, input int unsigned i, input logic a24);
      int unsigned s;
      s = int'(base) + i;
      return a24 ? 24'(s % 32'h0100_0000) : 24'(s % 32'h0001_0000);
   endfunction

   // Transaction-level expectations derived from the command byte sequence.
   task automatic model(input logic a24, input logic [7:0] tx[$], output bit oe_exp);
      int unsigned nab, nd;
      logic [23:0] base;
      oe_exp = 1'b0;
      nab = a24 ? 3 : 2;
      if (tx.size() == 0) return;
      if ((tx[0] == 8'h03 || tx[0] == 8'h02) && tx.size() >= 1 + nab) begin
         base = '0;
         for (int unsigned i = 1; i <= nab; i++) base = {base[15:0], tx[i]};
         nd = tx.size() - 1 - nab;
         if (tx[0] == 8'h03) begin
            oe_exp = 1'b1;
            for (int unsigned i = 0; i <= nd; i++) exp_re.push_back(wrap(base, i, a24));
            for (int unsigned i = 0; i < nd; i++) exp_rx.push_back(ref_rd(wrap(base, i, a24)));
         end else begin
            for (int unsigned i = 0; i < nd; i++) begin
               exp_we.push_back({wrap(base, i, a24), tx[1 + nab + i]});
               ref_mem[wrap(base, i, a24)] = tx[1 + nab + i];
            end
         end
      end
`ifdef SPI_MEM_RESPONDER_STATUS_EN
      else if (tx[0] == 8'h05) begin
         oe_exp = 1'b1;
         for (int unsigned i = 1; i < tx.size(); i++) exp_rx.push_back(mode_m);
      end else if (tx[0] == 8'h01 && tx.size() >= 2) begin
         mode_m = tx[1];
      end
`endif
   endtask

   task automatic send_bit(input logic b);
      mosi = b;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int b = 7; b >= 0; b--) send_bit(v[b]);
   endtask

   task automatic xfer(input logic a24, input logic [7:0] tx[$], input int unsigned tail);
      bit oe_exp;
      int unsigned oe0;
      model(a24, tx, oe_exp);
      addr_24bit = a24;
      oe0 = oe_cycles;
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      foreach (tx[i]) send_byte(tx[i]);
      for (int unsigned k = 0; k < tail; k++) send_bit(1'($urandom));
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      check("miso_oe_activity", 32'(oe_cycles != oe0), 32'(oe_exp));
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  q[$];
      logic [23:0] a;
      logic        a24;
      logic [7:0]  op;
      int unsigned kind, we0;

      repeat (3) @(negedge clk);
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_miso_oe", 32'(miso_oe), 32'd0);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      xfer(1'b0, q, 0);

      env_mem[24'h010000] = 8'h5A; ref_mem[24'h010000] = 8'h5A;
      env_mem[24'h010001] = 8'hC3; ref_mem[24'h010001] = 8'hC3;
      q = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      xfer(1'b1, q, 0);

      q = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};
      xfer(1'b0, q, 0);

      // Partial data byte then cs_n rise: no write, then a normal read.
      q = '{8'h02, 8'h00, 8'h10};
      xfer(1'b0, q, 5);
      q = '{8'h03, 8'h00, 8'h10, 8'h00};
      xfer(1'b0, q, 0);

      q = '{8'h9F, 8'h00, 8'h00};
      xfer(1'b0, q, 0);
      q = '{8'h03, 8'h12, 8'h34, 8'h00};
      xfer(1'b0, q, 0);

      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 3);
         a24  = 1'($urandom_range(0, 1));
         a    = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'h000100 + 24'($urandom_range(0, 15));
         if (!a24) a[23:16] = 8'h00;
         q.delete();
         if (kind == 2) begin
            do op = 8'($urandom); while (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h05);
            q.push_back(op);
            for (int unsigned i = 0; i < $urandom_range(1, 2); i++) q.push_back(8'($urandom));
         end else begin
            q.push_back(kind == 0 ? 8'h03 : 8'h02);
            if (a24) q.push_back(a[23:16]);
            q.push_back(a[15:8]);
            q.push_back(a[7:0]);
            for (int unsigned i = 0; i < $urandom_range(1, 3); i++) q.push_back(8'($urandom));
         end
         xfer(a24, q, 0);
      end

      q = '{8'h01, 8'h3C};
      xfer(1'b0, q, 0);
      q = '{8'h05, 8'h00, 8'h00};
      xfer(1'b0, q, 0);

      // Reset in the middle of a write data byte: no strobe, then wait for a fresh cs_n fall.
      we0 = we_cycles;
      addr_24bit = 1'b0;
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
      for (int b = 7; b >= 4; b--) send_bit(1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
`ifdef SPI_MEM_RESPONDER_STATUS_EN
      mode_m = 8'h40;
`endif
      for (int b = 0; b < 12; b++) send_bit(1'b1);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      check("rst_abort_no_we", we_cycles - we0, 32'd0);
      q = '{8'h03, 8'h00, 8'h20, 8'h00};
      xfer(1'b0, q, 0);

      q = '{8'h05, 8'h00};
      xfer(1'b0, q, 0);
      q = '{8'h01, 8'h00};
      xfer(1'b0, q, 0);
      q = '{8'h05, 8'h00};
      xfer(1'b0, q, 0);

      repeat (20) @(negedge clk);
      check("re_leftover", exp_re.size(), 32'd0);
      check("we_leftover", exp_we.size(), 32'd0);
      check("rx_leftover", exp_rx.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_mem_responder.md
SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

Interface
REQ-001 SHALL have parameter CLK_PER_SCLK_MIN, default 8, meaning minimum clk cycles per sclk period the design is guaranteed for.
REQ-002 SHALL have ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from initiator (mode 0).
- cs_n  in  1  active-low chip select.
- mosi  in  1  serial data from initiator.
- miso  out  1  serial data to initiator.
- miso_oe  out  1  high while a read or status byte is being driven.
- addr_24bit  in  1  1 = 3 address bytes, 0 = 2 address bytes; sampled at cs_n falling edge.
- mem_addr  out  24  memory word address.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid exactly one clk after mem_re.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  8  write data, valid with mem_we.

Function
REQ-003 SHALL synchronise sclk, cs_n and mosi through 2 flops and detect sclk rise/fall and cs_n fall/rise in the clk domain; all logic is clk-synchronous.
REQ-004 SHALL sample mosi on sclk rising edges, MSB first, and change miso only on sclk falling edges (mode 0).
REQ-005 SHALL implement states IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE.
REQ-006 IDLE -> CMD on cs_n fall; any state -> IDLE on cs_n rise, regardless of bit position.
REQ-007 CMD: after 8 bits, opcode 0x03 -> ADDR (read), 0x02 -> ADDR (write), anything else -> IGNORE.
REQ-008 ADDR: collects 16 or 24 bits per addr_24bit; in 16-bit mode mem_addr[23:16] = 0.
REQ-009 Read: mem_re pulses on the clk after the final address bit; mem_rdata loaded into the shift register the next clk; MSB on miso before the next sclk rise.
REQ-010 READ: after each 8th data bit, address increments, mem_re pulses, next byte loaded before the following sclk rise; sequential reads unbounded.
REQ-011 WRITE: after each complete 8-bit byte, mem_we pulses one clk with mem_addr/mem_wdata, then address increments.
REQ-012 Address increment wraps 0xFFFF -> 0x0000 (16-bit) or 0xFFFFFF -> 0x000000 (24-bit).
REQ-013 cs_n rise mid-byte SHALL discard the partial byte: no mem_we, no further mem_re.
REQ-014 miso_oe high only in READ/STATUS while cs_n low; miso = 0 whenever miso_oe low.
REQ-015 IGNORE: no strobes, miso_oe low, until cs_n rise.
REQ-016 mem_re and mem_we SHALL never be high in the same cycle.

Reset
REQ-017 On rst: state IDLE, miso 0, miso_oe 0, mem_re 0, mem_we 0, mem_addr 0, mem_wdata 0, bit counter 0, synchronisers in idle values (cs_n 1, sclk 0).
REQ-018 rst asserted mid-transfer aborts with no strobe; after release the block waits for a fresh cs_n fall.

Configuration
REQ-019 With SPI_MEM_RESPONDER_STATUS_EN defined: opcode 0x05 (RDSR) -> STATUS, shifting out the 8-bit mode register repeatedly; opcode 0x01 (WRSR) loads the next byte into the mode register; mode register resets to 0x40.
REQ-020 Without SPI_MEM_RESPONDER_STATUS_EN: 0x05 and 0x01 go to IGNORE; no mode register exists.

Structure
REQ-021 Package spi_mem_responder_pkg SHALL hold opcode constants (READ 0x03, WRITE 0x02, RDSR 0x05, WRSR 0x01), state enum, and mode-register reset value 0x40.
REQ-022 Sub-module spi_mem_responder_sync SHALL hold the 2-flop synchronisers and edge detectors.

Verification
REQ-023 16-bit write 0x02,0x12,0x34,0xAB,0xCD -> mem_we twice: (0x001234, 0xAB), (0x001235, 0xCD).
REQ-024 24-bit read 0x03,0x01,0x00,0x00 with memory 0x5A at 0x010000 and 0xC3 at 0x010001 -> miso returns 0x5A then 0xC3.
REQ-025 16-bit read at 0xFFFF, 2 bytes -> mem_re at 0x00FFFF then 0x000000.
REQ-026 Write 0x02,0x00,0x10 then 5 bits and cs_n rise -> no mem_we; a following 0x03 read succeeds normally.
REQ-027 Opcode 0x9F -> miso_oe stays 0, no strobes, next transaction after cs_n rise works.
REQ-028 With SPI_MEM_RESPONDER_STATUS_EN: RDSR after reset -> 0x40; WRSR 0x00 then RDSR -> 0x00; without the macro, RDSR -> miso_oe 0.
